// File: rtl/nibble_serial_addsub.sv
// 16-bit add/subtract computed one nibble per cycle through a 4-bit ripple adder.
// Optional signed-overflow output ovf enabled by NIBBLE_SERIAL_ADDSUB_OVF_EN.
module nibble_serial_addsub (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        mode,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        cout
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0] a_r;
  logic [15:0] b_r;
  logic        mode_r;
  logic [1:0]  cnt;
  logic        cy;
  logic [11:0] acc;

  logic [3:0]  an;
  logic [3:0]  yn;
  logic [4:0]  nib;
  logic        last;
  logic        accept;
  logic [15:0] res;

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == 2'd3);

  // Select the current nibble of each operand; b is inverted for subtract.
  always_comb begin
    an   = a_r[{cnt, 2'b00} +: 4];
    yn   = b_r[{cnt, 2'b00} +: 4] ^ {4{mode_r}};
    nib  = {1'b0, an} + {1'b0, yn} + {4'b0000, cy};
    res  = {nib[3:0], acc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, nibble sequencing and carry chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      mode_r <= 1'b0;
      cnt    <= '0;
      cy     <= 1'b0;
      acc    <= '0;
    end else if (accept) begin
      a_r    <= a;
      b_r    <= b;
      mode_r <= mode;
      cnt    <= '0;
      cy     <= mode;
      acc    <= '0;
    end else if (state == RUN) begin
      acc    <= {nib[3:0], acc[11:4]};
      cy     <= nib[4];
      cnt    <= cnt + 2'd1;
    end
  end

  // Result registers only change when the final nibble completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if ((state == RUN) && last) begin
      sum  <= res;
      cout <= nib[4];
    end
  end

`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
  logic y15;

  assign y15 = b_r[15] ^ mode_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if ((state == RUN) && last) begin
      ovf <= (a_r[15] == y15) && (res[15] != a_r[15]);
    end
  end
`endif

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed self-checking bench for nibble_serial_addsub.
// Covers reset, add/sub, ignored start, mid-run reset and back-to-back.
module tb_nibble_serial_addsub;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        mode;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
  logic        ovf;
`endif

  int checks;
  int errors;

  nibble_serial_addsub dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge (E0) and wait for done; lat = cycles E0 -> done.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                        input logic im, output int lat);
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = ia;
    b     = ib;
    mode  = im;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        break;
      end
      @(posedge clk);
      #1;
      lat = i;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    mode  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, sum, cout} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b want 0 0 0000 0",
               busy, done, sum, cout);
    end
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got %b want 0", ovf);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_add;
    int lat;
    run_op(16'h1234, 16'h0FFF, 1'b0, lat);
    checks++;
    if (lat !== 4 || done !== 1'b1) begin
      errors++;
      $display("FAIL add_latency got %0d want 4", lat);
    end
    checks++;
    if (sum !== 16'h2233 || cout !== 1'b0) begin
      errors++;
      $display("FAIL add_1234 got %h/%b want 2233/0", sum, cout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
    run_op(16'hFFFF, 16'h0001, 1'b0, lat);
    checks++;
    if (sum !== 16'h0000 || cout !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap got %h/%b want 0000/1", sum, cout);
    end
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap_ovf got %b want 0", ovf);
    end
`endif
  endtask

  task automatic test_sub;
    int lat;
    run_op(16'h0005, 16'h0003, 1'b1, lat);
    checks++;
    if (sum !== 16'h0002 || cout !== 1'b1) begin
      errors++;
      $display("FAIL sub_5_3 got %h/%b want 0002/1", sum, cout);
    end
    run_op(16'h0003, 16'h0005, 1'b1, lat);
    checks++;
    if (sum !== 16'hFFFE || cout !== 1'b0) begin
      errors++;
      $display("FAIL sub_3_5 got %h/%b want FFFE/0", sum, cout);
    end
    run_op(16'h0000, 16'h0000, 1'b1, lat);
    checks++;
    if (sum !== 16'h0000 || cout !== 1'b1) begin
      errors++;
      $display("FAIL sub_0_0 got %h/%b want 0000/1", sum, cout);
    end
  endtask

`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
  task automatic test_ovf;
    int lat;
    run_op(16'h7FFF, 16'h0001, 1'b0, lat);
    checks++;
    if (sum !== 16'h8000 || ovf !== 1'b1 || cout !== 1'b0) begin
      errors++;
      $display("FAIL ovf_add got %h/%b/%b want 8000/1/0", sum, ovf, cout);
    end
    run_op(16'h8000, 16'h0001, 1'b1, lat);
    checks++;
    if (sum !== 16'h7FFF || ovf !== 1'b1 || cout !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sub got %h/%b/%b want 7FFF/1/1", sum, ovf, cout);
    end
  endtask
`endif

  task automatic test_ignore_start;
    int lat;
    int busy_drop;
    busy_drop = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h0FFF;
    mode  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (!busy) busy_drop++;
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'h0001;
    mode  = 1'b1;
    if (!busy) busy_drop++;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (!busy) busy_drop++;
    lat = 2;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      if (!busy) busy_drop++;
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (busy_drop !== 0 || lat !== 4) begin
      errors++;
      $display("FAIL ignore_busy got drops=%0d lat=%0d want 0 4", busy_drop, lat);
    end
    checks++;
    if (sum !== 16'h2233 || cout !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result got %h/%b want 2233/0", sum, cout);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_restart got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_midrun;
    int lat;
    int seen;
    seen = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'h0F0F;
    b     = 16'h0101;
    mode  = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got busy=%b sum=%h cout=%b want 0 0000 0",
               busy, sum, cout);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done || sum !== 16'h0000) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_no_done got %0d events want 0", seen);
    end
    run_op(16'h0F0F, 16'h0101, 1'b0, lat);
    checks++;
    if (lat !== 4 || sum !== 16'h1010 || cout !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover got lat=%0d %h/%b want 4 1010/0", lat, sum, cout);
    end
  endtask

  task automatic test_back_to_back;
    int gap;
    logic hold_ok;
    hold_ok = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h0FFF;
    mode  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    checks++;
    if (done !== 1'b1 || sum !== 16'h2233) begin
      errors++;
      $display("FAIL b2b_first got done=%b sum=%h want 1 2233", done, sum);
    end
    a    = 16'h0005;
    b    = 16'h0003;
    mode = 1'b1;
    gap  = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      gap++;
      if (done) break;
      if (sum !== 16'h2233) hold_ok = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (gap !== 6 || hold_ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap got gap=%0d hold=%b want 6 1", gap, hold_ok);
    end
    checks++;
    if (sum !== 16'h0002 || cout !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second got %h/%b want 0002/1", sum, cout);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
`ifdef NIBBLE_SERIAL_ADDSUB_OVF_EN
    test_ovf();
`endif
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports clk and rst are listed first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request a 16-bit operation; sampled only in IDLE.
REQ-005 a  input  16  minuend/augend, captured when start is accepted.
REQ-006 b  input  16  subtrahend/addend, captured when start is accepted.
REQ-007 mode  input  1  0 = add, 1 = subtract (a - b), captured when start is accepted.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse; result valid.
REQ-010 sum  output  16  registered result.
REQ-011 cout  output  1  registered carry out of bit 15; for subtract, 1 = no borrow.

Function
REQ-012 SHALL compute a + (b XOR {16{mode}}) + mode, one 4-bit nibble per cycle, LSB nibble first, through an internal 4-bit ripple adder with a registered carry.
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
- IDLE -> RUN on start = 1.
- RUN -> DONE after the 4th nibble.
- DONE -> IDLE unconditionally.
REQ-014 When start is sampled high in IDLE at edge E0:
- a, b and mode SHALL be latched.
- The nibble counter SHALL be set to 0.
- The carry register SHALL be loaded with mode.
REQ-015 Nibble k (k = 0..3) SHALL be computed at edge E(k+1).
- Its 4-bit sum SHALL be stored in the accumulator.
- Its carry out SHALL become the carry-in for nibble k+1.
REQ-016 At edge E4:
- sum and cout SHALL be loaded from the accumulator and final carry.
- done SHALL be 1 for exactly one cycle, between E4 and E5.
- Latency from start sample to done is 4 cycles.
REQ-017 busy SHALL be 1 from after E0 until E4, and 0 in IDLE and DONE.
REQ-018 sum and cout SHALL hold their values until the next E4; partial nibbles SHALL never appear on sum.
REQ-019 start SHALL be ignored in RUN and DONE, and operand or mode changes after E0 SHALL not affect the operation in flight.
REQ-020 Back-to-back operation: start held high SHALL be accepted in IDLE one cycle after done, giving one result every 6 cycles.
REQ-021 All arithmetic SHALL be modulo 2^16.

Reset
REQ-022 On rst = 1, at any time, the block SHALL asynchronously force:
- state = IDLE;
- busy = 0, done = 0, sum = 16'h0000, cout = 0;
- counter, carry, accumulator and operand registers = 0.
REQ-023 An operation interrupted by reset SHALL be abandoned, with no done pulse and no sum update.
REQ-024 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-025 The macro NIBBLE_SERIAL_ADDSUB_OVF_EN SHALL control a registered signed-overflow output.
- Defined: output port ovf (1 bit) exists. It SHALL be loaded at E4 with (a[15] == y[15]) AND (sum[15] != a[15]), where y = b XOR {16{mode}}. Its reset value is 0 and it holds like sum.
- Undefined: port ovf and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-026 a = 16'h1234, b = 16'h0FFF, mode = 0 -> done 4 cycles after start; sum = 16'h2233, cout = 0.
REQ-027 a = 16'hFFFF, b = 16'h0001, mode = 0 -> sum = 16'h0000, cout = 1; with the macro defined, ovf = 0.
REQ-028 Subtract cases:
- a = 16'h0005, b = 16'h0003, mode = 1 -> sum = 16'h0002, cout = 1.
- a = 16'h0003, b = 16'h0005, mode = 1 -> sum = 16'hFFFE, cout = 0.
REQ-029 With the macro defined:
- a = 16'h7FFF, b = 16'h0001, mode = 0 -> sum = 16'h8000, ovf = 1.
- a = 16'h8000, b = 16'h0001, mode = 1 -> sum = 16'h7FFF, ovf = 1.
REQ-030 Pulse start again in the 2nd RUN cycle with different operands -> ignored; first result unchanged; busy continuous.
REQ-031 Assert rst in the 3rd RUN cycle -> busy = 0 and sum = 0 immediately; no done pulse; a new start after release gives the correct result.
